// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO architectural registers.
// Results are computed at accept time and committed atomically when the countdown expires.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_t;

    md_op_t op_e;
    assign op_e = md_op_t'(op);

    logic [CW-1:0]      count;
    logic               busy_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   pend_hi, pend_lo;
    logic               pend_wr;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_wr;

    // Division is evaluated only under a nonzero divisor and outside the
    // most-negative / -1 case, so neither path ever reaches the divider.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b0;
        prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        case (op_e)
            OP_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_wr = 1'b1;
            end
            OP_DIV: begin
                if (b != '0) begin
                    res_wr = 1'b1;
                    if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) begin
                        res_lo = a;
                        res_hi = '0;
                    end else begin
                        res_lo = $signed(a) / $signed(b);
                        res_hi = $signed(a) % $signed(b);
                    end
                end
            end
            OP_DIVU: begin
                if (b != '0) begin
                    res_wr = 1'b1;
                    res_lo = a / b;
                    res_hi = a % b;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else if (busy_q) begin
            count <= count - 1'b1;
            if (count == CW'(1)) begin
                busy_q <= 1'b0;
                if (pend_wr) begin
                    hi_q <= pend_hi;
                    lo_q <= pend_lo;
                end
            end
        end else if (start) begin
            case (op_e)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    busy_q  <= 1'b1;
                    count   <= (op_e == OP_MULT || op_e == OP_MULTU) ? CW'(MULT_CYCLES)
                                                                     : CW'(DIV_CYCLES);
                    pend_hi <= res_hi;
                    pend_lo <= res_lo;
                    pend_wr <= res_wr;
                end
                OP_MTHI: hi_q <= a;
                OP_MTLO: lo_q <= a;
                default: ;
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, results, hold during busy, ignore rules and reset abort.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    logic        s_reset, s_start;
    logic [2:0]  s_op;
    logic [31:0] s_a, s_b;
    logic        s_busy;
    logic [31:0] s_hi, s_lo;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo)
    );

    md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut_s (
        .clk(clk), .reset(s_reset), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
        .busy(s_busy), .hi(s_hi), .lo(s_lo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue one arithmetic op, watch it for its whole busy window, then check the commit.
    // inj > 0 drives a start/mthi during that busy cycle, which must be ignored.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int n_exp, input int inj,
                          input logic [31:0] h_new, input logic [31:0] l_new);
        int n;
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0; op = 3'd0;
        n = 0;
        while (busy && n < 64) begin
            n++;
            check({tag, "_hold_hi"}, hi, exp_hi);
            check({tag, "_hold_lo"}, lo, exp_lo);
            if (n == inj) begin
                start = 1'b1; op = 3'd5; a = 32'h0000DEAD;
            end
            step();
            start = 1'b0; op = 3'd0;
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(n_exp));
        exp_hi = h_new;
        exp_lo = l_new;
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        s_reset = 1'b1; s_start = 1'b0; s_op = '0; s_a = '0; s_b = '0;
        step(); step();
        reset = 1'b0; s_reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        run_op("mult",  3'd1, 32'hFFFFFFFD, 32'd5, 5, 0, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 5, 0, 32'h00000001, 32'hFFFFFFFE);
        run_op("div",   3'd3, 32'hFFFFFFF9, 32'd2, 10, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",  3'd4, 32'd7,        32'd2, 10, 0, 32'd1,        32'd3);

        start = 1'b1; op = 3'd5; a = 32'h12345678;
        step();
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_lo", lo, 32'd3);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        op = 3'd6; a = 32'h9ABCDEF0;
        step();
        start = 1'b0; op = 3'd0;
        check("mtlo_lo", lo, 32'h9ABCDEF0);
        check("mtlo_hi", hi, 32'h12345678);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        exp_hi = 32'h12345678; exp_lo = 32'h9ABCDEF0;

        start = 1'b1; op = 3'd0; a = 32'h55555555;
        step();
        op = 3'd7;
        step();
        start = 1'b0;
        check("nop_busy", {31'd0, busy}, 32'd0);
        check("nop_hi", hi, exp_hi);
        check("nop_lo", lo, exp_lo);

        run_op("div0",    3'd3, 32'd100,      32'd0,        10, 0, 32'h12345678, 32'h9ABCDEF0);
        run_op("mult_ig", 3'd1, 32'd2,        32'd3,        5,  2, 32'd0,        32'd6);
        run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 0, 32'd0,        32'h80000000);
        run_op("div_neg", 3'd3, 32'd7,        32'hFFFFFFFE, 10, 0, 32'd1,        32'hFFFFFFFD);
        run_op("divu_big",3'd4, 32'hFFFFFFFF, 32'h10,       10, 0, 32'hF,        32'h0FFFFFFF);

        // Reset four cycles into a divide must abort it with no late commit.
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        step();
        start = 1'b0; op = 3'd0;
        for (int i = 0; i < 3; i++) step();
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("abort_late_hi", hi, 32'd0);
            check("abort_late_lo", lo, 32'd0);
            check("abort_late_busy", {31'd0, busy}, 32'd0);
        end

        // Single-cycle configuration; the start on the commit edge must be dropped.
        s_start = 1'b1; s_op = 3'd1; s_a = 32'd4; s_b = 32'd5;
        step();
        check("s_mult_busy", {31'd0, s_busy}, 32'd1);
        check("s_mult_hold", s_lo, 32'd0);
        s_op = 3'd5; s_a = 32'h0000BEEF;
        step();
        s_start = 1'b0; s_op = 3'd0;
        check("s_mult_done", {31'd0, s_busy}, 32'd0);
        check("s_mult_lo", s_lo, 32'd20);
        check("s_mult_hi", s_hi, 32'd0);
        s_start = 1'b1; s_op = 3'd3; s_a = 32'd9; s_b = 32'd2;
        step();
        s_start = 1'b0; s_op = 3'd0;
        check("s_div_busy", {31'd0, s_busy}, 32'd1);
        step();
        check("s_div_done", {31'd0, s_busy}, 32'd0);
        check("s_div_lo", s_lo, 32'd4);
        check("s_div_hi", s_hi, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
